// File: rtl/pipe_stage_buffer_if.sv
// pipe_stage_buffer_if
//   Valid/ready handshake bundle between two pipeline stages.
//   master : upstream producer / downstream consumer side (drives in_*, out_ready)
//   slave  : the stage buffer itself (drives in_ready, out_*)
//   Signals: in_valid, in_ready, in_ctrl[CTRL_W], in_data[DATA_W],
//            out_valid, out_ready, out_ctrl[CTRL_W], out_data[DATA_W]
interface pipe_stage_buffer_if #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer
//   Pipeline stage register with valid/ready handshake and a two-entry skid
//   buffer (main + skid). in_ready and out_valid come straight from flops, so
//   there is no combinational path from out_ready to in_ready. Empty or
//   flushed slots present all-zero control. State updates on the falling edge.
//
//   Ports: clk    - clock (falling edge active)
//          reset  - asynchronous active-low reset
//          flush  - synchronous flush, drops held and incoming entries
//          bus    - pipe_stage_buffer_if.slave handshake/payload bundle
//          stall_cnt, bubble_cnt - saturating statistics counters, present
//                   only when PIPE_STAGE_STATS_EN is defined
//
//   state   | meaning
//   --------+------------------------------------------
//   S_EMPTY | nothing held, out_valid=0, in_ready=1
//   S_ONE   | main entry valid, skid empty
//   S_TWO   | main and skid valid, in_ready=0
module pipe_stage_buffer #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  pipe_stage_buffer_if.slave bus
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] bubble_cnt
`endif
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, out_valid_q;
  logic              accept, pop;

  assign accept = bus.in_valid & in_ready_q;
  assign pop    = out_valid_q & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = S_EMPTY;
      main_ctrl_d = '0;
      main_data_d = '0;
      skid_ctrl_d = '0;
      skid_data_d = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d     = S_ONE;
            main_ctrl_d = bus.in_ctrl;
            main_data_d = bus.in_data;
          end
        end
        S_ONE: begin
          if (accept && pop) begin
            main_ctrl_d = bus.in_ctrl;
            main_data_d = bus.in_data;
          end else if (accept) begin
            state_d     = S_TWO;
            skid_ctrl_d = bus.in_ctrl;
            skid_data_d = bus.in_data;
          end else if (pop) begin
            // data is left in place so the bus does not toggle on a bubble
            state_d     = S_EMPTY;
            main_ctrl_d = '0;
          end
        end
        S_TWO: begin
          if (pop) begin
            state_d     = S_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= (state_d != S_TWO);
      out_valid_q <= (state_d != S_EMPTY);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  // main_ctrl is already zero when empty; the gate makes that unconditional
  assign bus.out_ctrl  = out_valid_q ? main_ctrl_q : '0;
  assign bus.out_data  = main_data_q;

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_q, bubble_q;

  // cleared by reset only; flush deliberately leaves the counts alone
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (out_valid_q && !bus.out_ready && (stall_q != 16'hFFFF))
        stall_q <= stall_q + 16'd1;
      if (!out_valid_q && (bubble_q != 16'hFFFF))
        bubble_q <= bubble_q + 16'd1;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
module tb_pipe_stage_buffer;
  localparam int DW = 96;
  localparam int CW = 16;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic clk;
  logic reset;
  logic flush;

  pipe_stage_buffer_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_cnt, bubble_cnt;
`endif

  pipe_stage_buffer #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  ent_t          q[$];
  logic [DW-1:0] last_data;
  bit            acc_last;
  logic [15:0]   stall_m, bubble_m;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit ev;
    ev = (q.size() > 0);
    chk("out_valid", {127'd0, bus.out_valid}, {127'd0, ev});
    chk("in_ready", {127'd0, bus.in_ready}, {127'd0, q.size() < 2});
    chk("out_ctrl", {112'd0, bus.out_ctrl}, ev ? {112'd0, q[0].c} : 128'd0);
    chk("out_data", {32'd0, bus.out_data}, ev ? {32'd0, q[0].d} : {32'd0, last_data});
`ifdef PIPE_STAGE_STATS_EN
    chk("stall_cnt", {112'd0, stall_cnt}, {112'd0, stall_m});
    chk("bubble_cnt", {112'd0, bubble_cnt}, {112'd0, bubble_m});
`endif
  endtask

  // Model the falling edge from the currently driven inputs, then let the
  // edge happen and compare at the following rising edge.
  task automatic cycle(input bit do_check = 1'b1);
    bit   acc, pp;
    ent_t e;
    acc = bus.in_valid && (q.size() < 2);
    pp  = bus.out_ready && (q.size() > 0);
    if (q.size() > 0 && !bus.out_ready && stall_m != 16'hFFFF) stall_m++;
    if (q.size() == 0 && bubble_m != 16'hFFFF) bubble_m++;
    if (flush) begin
      q.delete();
      last_data = '0;
    end else begin
      if (pp) begin
        last_data = q[0].d;
        void'(q.pop_front());
      end
      if (acc) begin
        e.c = bus.in_ctrl;
        e.d = bus.in_data;
        q.push_back(e);
      end
    end
    acc_last = acc;
    @(negedge clk);
    @(posedge clk);
    if (do_check) check_outputs();
  endtask

  task automatic drive(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    bus.in_valid = v;
    bus.in_ctrl  = c;
    bus.in_data  = d;
  endtask

  initial begin
    int n;
    logic [DW-1:0] dc;
    reset = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, '0);
    last_data = '0;
    acc_last = 1'b0;
    stall_m = '0;
    bubble_m = '0;

    #12;
    check_outputs();
    reset = 1'b1;

    // first entry, then 8 back-to-back at full throughput
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h0041, 96'h1000);
    cycle();
    chk("first_ctrl", {112'd0, bus.out_ctrl}, 128'h41);
    chk("first_data", {32'd0, bus.out_data}, 128'h1000);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'h0041 + CW'(i), 96'h1000 + DW'(i));
      cycle();
    end
    drive(1'b0, '0, '0);
    cycle();

    // backpressure: A in main, B in skid, C held upstream
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h00A1, 96'hA_0000);
    cycle();
    drive(1'b1, 16'h00B2, 96'hB_0000);
    cycle();
    chk("skid_full_ready", {127'd0, bus.in_ready}, 128'd0);
    dc = 96'hC_0000;
    drive(1'b1, 16'h00C3, dc);
    cycle();
    cycle();
    bus.out_ready = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!acc_last && n < 10);
    chk("c_accept_bound", {127'd0, acc_last}, 128'd1);
    drive(1'b0, '0, '0);
    cycle();
    chk("empty_ctrl", {112'd0, bus.out_ctrl}, 128'd0);
    chk("empty_data_hold", {32'd0, bus.out_data}, {32'd0, dc});

    // flush while in TWO, with an entry offered in the same cycle
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h00D4, 96'hD_0000);
    cycle();
    drive(1'b1, 16'h00E5, 96'hE_0000);
    cycle();
    drive(1'b1, 16'h00F6, 96'hF_0000);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("flush_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("flush_data", {32'd0, bus.out_data}, 128'd0);
    chk("flush_ready", {127'd0, bus.in_ready}, 128'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // asynchronous reset between edges while in TWO
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h0107, 96'h7_0000);
    cycle();
    drive(1'b1, 16'h0208, 96'h8_0000);
    cycle();
    drive(1'b0, '0, '0);
    reset = 1'b0;
    #1;
    q.delete();
    last_data = '0;
    stall_m = '0;
    bubble_m = '0;
    check_outputs();
    chk("arst_ready", {127'd0, bus.in_ready}, 128'd1);
    #2;
    reset = 1'b1;
    cycle();

    // randomised traffic with occasional flush
    for (int i = 0; i < 300; i++) begin
      flush = ($urandom_range(0, 19) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus.in_valid || acc_last)
        drive($urandom_range(0, 3) != 0, CW'($urandom), {$urandom, $urandom, $urandom});
      cycle();
    end
    flush = 1'b0;
    drive(1'b0, '0, '0);
    bus.out_ready = 1'b1;
    cycle();
    cycle();

`ifdef PIPE_STAGE_STATS_EN
    // stall counter saturation, flush retention, reset clear
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h0309, 96'h9_0000);
    cycle();
    drive(1'b0, '0, '0);
    for (int i = 0; i < 70000; i++) cycle(1'b0);
    cycle();
    chk("stall_sat", {112'd0, stall_cnt}, 128'hFFFF);
    cycle();
    chk("stall_hold", {112'd0, stall_cnt}, 128'hFFFF);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();
    reset = 1'b0;
    #1;
    q.delete();
    last_data = '0;
    stall_m = '0;
    bubble_m = '0;
    chk("stats_rst_stall", {112'd0, stall_cnt}, 128'd0);
    chk("stats_rst_bubble", {112'd0, bubble_cnt}, 128'd0);
    #2;
    reset = 1'b1;
    cycle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_buffer.md
# pipe_stage_buffer

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and guaranteed bubble insertion. It is the next generation of the fixed-field stage registers between ID/EX/MEM/WB. Backpressure propagates one stage per cycle without a combinational ready path, and flushed or empty slots present all-zero control. Control and data fields are carried as packed vectors so one block serves every stage boundary.

## Interface
- DATA_W, 96, packed datapath payload width (pc, operands, imm, ...)
- CTRL_W, 16, packed control payload width (reg_write, mem_read, mem_write, branch, alu_op, ...)
- clk  input  1  clock; all state updates on the falling edge
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous flush; discards all held and incoming entries
- in_valid  input  1  upstream entry present
- in_ready  output  1  stage can accept an entry this cycle (registered)
- in_ctrl  input  CTRL_W  upstream control payload
- in_data  input  DATA_W  upstream data payload
- out_valid  output  1  entry presented downstream
- out_ready  input  1  downstream accepts the presented entry
- out_ctrl  output  CTRL_W  control payload; forced 0 whenever out_valid=0
- out_data  output  DATA_W  data payload
- stall_cnt  output  16  saturating stall counter (only with PIPE_STAGE_STATS_EN)
- bubble_cnt  output  16  saturating bubble counter (only with PIPE_STAGE_STATS_EN)

## Operation
- Storage: main entry (drives out_*) and skid entry; state EMPTY, ONE (main valid), TWO (main+skid valid).
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = !skid_valid (register output, no path from out_ready). out_valid = main_valid.
- EMPTY: accept -> ONE, main <= input; else hold.
- ONE: accept&pop -> ONE, main <= input; accept&!pop -> TWO, skid <= input; !accept&pop -> EMPTY, main_ctrl <= 0; neither -> hold.
- TWO: pop -> ONE, main <= skid, skid_ctrl <= 0; else hold. in_valid is ignored (in_ready=0).
- flush (priority over all transitions): state -> EMPTY, main/skid ctrl and data <= 0; an entry offered in the flush cycle is dropped; in_ready=1 next cycle.
- Entry order strictly FIFO; no entry duplicated or lost except by flush.
- out_data holds its last value after a pop to EMPTY; it is 0 after reset or flush.

## Timing
- Reset (reset=0, asynchronous): state EMPTY, out_valid=0, out_ctrl=0, out_data=0, in_ready=1, skid cleared, counters 0.
- Latency: entry accepted at falling edge N is on out_* immediately after edge N (one cycle).
- Throughput: one entry per cycle while out_ready=1.
- in_ready drops to 0 after the edge that fills skid; it returns to 1 after the edge that empties skid.
- Reset asserted mid-transfer: every held entry is discarded at once; the state after release is identical to power-up.
- flush together with pop: the pop is not counted as a transfer downstream (downstream must also honour flush).

## Configuration
- PIPE_STAGE_STATS_EN defined: stall_cnt increments each edge with out_valid&!out_ready; bubble_cnt increments each edge with out_valid=0. Both saturate at 0xFFFF, are cleared only by reset (not by flush), and are unaffected by their own saturation.
- Not defined: both counters and ports are absent; there is no additional logic.

## Test plan
- Reset release, in_valid=1, in_ctrl=0x0041, in_data=0x...1000, out_ready=1 -> out_valid=1, out_ctrl=0x0041 one cycle later; 8 back-to-back entries leave in order at 1/cycle.
- out_ready=0 with entries A,B,C offered -> A on out, B in skid, in_ready=0, C held upstream; out_ready=1 -> A, B, C emerge on consecutive cycles.
- Pop to EMPTY -> out_valid=0, out_ctrl=0x0000, out_data unchanged.
- State TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, out_data=0, in_ready=1; the flush-cycle input is never output.
- Asynchronous reset between edges while in TWO -> outputs zero immediately, in_ready=1.
- STATS_EN: out_ready=0 for 70000 cycles with out_valid=1 -> stall_cnt=0xFFFF and holds; flush leaves counts unchanged; reset clears them.
